param_alu: RTL and testbench



---
 rtl/param_alu.sv | 148 ++++++++++++++
 tb/tb_param_alu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/param_alu.sv
// Queued ALU: WIDTH-bit operand pairs go through a DEPTH-entry command FIFO and execute in order.
// Define PARAM_ALU_SUB_EN to enable op 101 (subtract); otherwise 101 is discarded like no_op.
module param_alu #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int unsigned RW  = 2 * WIDTH;
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_RST = 3'b111;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    cmd_t             fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    state_t           state;
    cmd_t             cur;
    logic [MCW-1:0]   mul_cnt;
    logic             op_queued;
    logic             rst_op;
    logic             push;
    logic             pop;

    // Only opcodes that produce a result occupy a FIFO slot.
    always_comb begin
        op_queued = 1'b0;
        case (op)
            OP_ADD, OP_AND, OP_XOR, OP_MUL: op_queued = 1'b1;
`ifdef PARAM_ALU_SUB_EN
            OP_SUB:                         op_queued = 1'b1;
`endif
            default:                        op_queued = 1'b0;
        endcase
    end

    assign rst_op     = start && (op == OP_RST);
    assign push       = start && ready && op_queued;
    assign pop        = ((state == S_IDLE) || (state == S_DONE)) && (count != '0);
    assign count_next = count + CW'(push) - CW'(pop);

    function automatic logic [RW-1:0] alu_exec(input cmd_t c);
        logic [RW-1:0] r;
        r = '0;
        case (c.op)
            OP_ADD:  r = RW'(c.a) + RW'(c.b);
            OP_AND:  r = RW'(c.a & c.b);
            OP_XOR:  r = RW'(c.a ^ c.b);
`ifdef PARAM_ALU_SUB_EN
            OP_SUB:  r = RW'(c.a) - RW'(c.b);
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr] <= cmd_t'{a: A, b: B, op: op};
        end
    end

    // Control FSM; reset and rst_op share the clear path, only ready differs.
    always_ff @(posedge clk) begin
        if (reset || rst_op) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            state   <= S_IDLE;
            cur     <= '0;
            mul_cnt <= '0;
            done    <= 1'b0;
            result  <= '0;
            busy    <= 1'b0;
            ready   <= !reset;
        end else begin
            done  <= 1'b0;
            count <= count_next;
            ready <= (count_next != CW'(DEPTH));
            busy  <= pop || (state == S_EXEC) || (state == S_MUL) || (count_next != '0);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (pop) begin
                        cur <= fifo_mem[rd_ptr];
                        if (fifo_mem[rd_ptr].op == OP_MUL) begin
                            state   <= S_MUL;
                            mul_cnt <= MCW'(MUL_CYCLES - 1);
                        end else begin
                            state <= S_EXEC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    result <= alu_exec(cur);
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_MUL: begin
                    if (mul_cnt == '0) begin
                        result <= RW'(cur.a) * RW'(cur.b);
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        mul_cnt <= mul_cnt - MCW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_alu.sv
// Scoreboard bench for param_alu: stimulus queues expected result and done cycle, a monitor checks each done.
module tb_param_alu;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned MUL_CYCLES = 3;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] ADD  = 3'b001;
    localparam logic [2:0] AND_ = 3'b010;
    localparam logic [2:0] XOR_ = 3'b011;
    localparam logic [2:0] MUL  = 3'b100;
    localparam logic [2:0] SUB  = 3'b101;
    localparam logic [2:0] RSV  = 3'b110;
    localparam logic [2:0] RST  = 3'b111;

    logic               clk = 1'b0;
    logic               reset;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         op;
    logic               start;
    logic               ready;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic               busy;

    typedef struct {
        logic [15:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   last_done = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    param_alu #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
        .ready(ready), .done(done), .result(result), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit queued(input logic [2:0] o);
        case (o)
            ADD, AND_, XOR_, MUL: return 1'b1;
`ifdef PARAM_ALU_SUB_EN
            SUB:                  return 1'b1;
`endif
            default:              return 1'b0;
        endcase
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                e = sb.pop_front();
                check("missing_done", 32'(done), 32'd1);
            end
        end
    endtask

    // Presents one command for one cycle; called and returns at posedge+1.
    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] res, input logic exp_rdy);
        int pop_c;
        int lat;
        op = o; A = a; B = b; start = 1'b1;
        check("ready", 32'(ready), 32'(exp_rdy));
        @(posedge clk); #1;
        if (o == RST) begin
            sb.delete();
            last_done = 0;
        end else if (exp_rdy && queued(o)) begin
            lat   = (o == MUL) ? MUL_CYCLES : 1;
            pop_c = (cyc + 1 > last_done + 1) ? cyc + 1 : last_done + 1;
            last_done = pop_c + lat;
            sb.push_back('{res: res, cyc: last_done});
        end
    endtask

    task automatic idle(input int n);
        start = 1'b0; op = NOP;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        start = 1'b0; op = NOP;
        for (int i = 0; i < max_cycles && (busy !== 1'b0 || sb.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    logic [7:0]  fa [6] = '{8'h02, 8'h0F, 8'hAA, 8'h12, 8'hFF, 8'h07};
    logic [7:0]  fb [6] = '{8'h03, 8'h11, 8'h02, 8'h34, 8'h02, 8'h07};
    logic [15:0] fr [6] = '{16'h0006, 16'h00FF, 16'h0154, 16'h03A8, 16'h01FE, 16'h0031};
    logic        fy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = NOP; A = '0; B = '0;
        fork
            monitor();
        join_none

        repeat (2) begin
            @(posedge clk); #1;
            check("reset_ready", 32'(ready), 32'd0);
            check("reset_done", 32'(done), 32'd0);
            check("reset_result", 32'(result), 32'd0);
            check("reset_busy", 32'(busy), 32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(ready), 32'd1);

        // add with carry into bit WIDTH
        issue(ADD, 8'hFF, 8'h01, 16'h0100, 1'b1);
        wait_idle(20);

        // mul latency followed by queued and/xor
        issue(MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b1);
        issue(AND_, 8'hF0, 8'h3C, 16'h0030, 1'b1);
        issue(XOR_, 8'hF0, 8'h3C, 16'h00CC, 1'b1);
        wait_idle(40);

        // no_op and reserved are discarded
        issue(NOP, 8'h11, 8'h22, 16'h0000, 1'b1);
        issue(RSV, 8'h33, 8'h44, 16'h0000, 1'b1);
        idle(6);
        check("discard_result_held", 32'(result), 32'h00CC);

        // FIFO fill with start held high
        for (int i = 0; i < 6; i++) issue(MUL, fa[i], fb[i], fr[i], fy[i]);
        wait_idle(80);
        check("full_last_result", 32'(result), 32'h01FE);

        // rst_op while full
        for (int i = 0; i < 5; i++) issue(MUL, 8'(i + 1), 8'(i + 1), 16'((i + 1) * (i + 1)), 1'b1);
        issue(RST, 8'h00, 8'h00, 16'h0000, 1'b0);
        start = 1'b0; op = NOP;
        check("rstop_result", 32'(result), 32'd0);
        check("rstop_busy", 32'(busy), 32'd0);
        check("rstop_ready", 32'(ready), 32'd1);
        check("rstop_done", 32'(done), 32'd0);
        idle(8);
        issue(ADD, 8'h03, 8'h04, 16'h0007, 1'b1);
        wait_idle(20);

        // subtract, or discard when the subtractor is not built
        issue(SUB, 8'h01, 8'h02, 16'hFFFF, 1'b1);
        wait_idle(20);
        idle(4);
`ifdef PARAM_ALU_SUB_EN
        check("sub_result", 32'(result), 32'h0000FFFF);
`else
        check("sub_disabled_result", 32'(result), 32'h00000007);
`endif

        // reset during MUL
        issue(MUL, 8'h09, 8'h09, 16'h0051, 1'b1);
        idle(2);
        reset = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        last_done = 0;
        check("midmul_done", 32'(done), 32'd0);
        check("midmul_result", 32'(result), 32'd0);
        check("midmul_busy", 32'(busy), 32'd0);
        check("midmul_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midmul_ready_after", 32'(ready), 32'd1);
        idle(8);
        check("midmul_result_after", 32'(result), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
